// File: rtl/clock_failover_controller.sv
`default_nettype none
// ============================================================================
//  Module      : clock_failover_controller
//  Description : Heartbeat-based health monitor for two clock sources with a
//                request/acknowledge switchover handshake and revert policy.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_failover_controller #(
    parameter int TIMEOUT   = 16,
    parameter int RECOVERY  = 4,
    parameter int PREFERRED = 0,
    parameter int REVERTIVE = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       first_heartbeat,
    input  logic       second_heartbeat,
    input  logic       switch_acknowledge,
    output logic       select,
    output logic       switch_request,
    output logic       first_alive,
    output logic       second_alive,
    output logic       no_clock,
    output logic [7:0] switch_count
);

    localparam logic [7:0] c_timeout   = 8'(TIMEOUT);
    localparam logic [3:0] c_recovery  = 4'(RECOVERY);
    localparam logic       c_preferred = 1'(PREFERRED);
    localparam logic       c_revertive = 1'(REVERTIVE);

    localparam logic [1:0] c_st_none      = 2'd0;
    localparam logic [1:0] c_st_run       = 2'd1;
    localparam logic [1:0] c_st_switching = 2'd2;

    logic [1:0] w_heartbeat;
    logic [1:0] w_alive;

    assign w_heartbeat = {second_heartbeat, first_heartbeat};

    // Identical monitor for each source: silence and good-toggle counters
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_monitor
        logic       r_prev;
        logic [7:0] r_silence;
        logic [3:0] r_good;
        logic       r_alive;
        logic       w_toggle;
        logic       w_expired;

        assign w_toggle  = w_heartbeat[gi] ^ r_prev;
        assign w_expired = (r_silence == c_timeout);

        always_ff @(posedge clock) begin
            r_prev <= w_heartbeat[gi];
            if (reset) begin
                r_silence <= 8'd0;
                r_good    <= 4'd0;
                r_alive   <= 1'b0;
            end else begin
                if (w_toggle) begin
                    r_silence <= 8'd0;
                end else if (!w_expired) begin
                    r_silence <= r_silence + 8'd1;
                end

                // A toggle arriving after a full timeout starts a fresh streak
                if (w_expired) begin
                    r_good <= {3'b000, w_toggle};
                end else if (w_toggle && (r_good != c_recovery)) begin
                    r_good <= r_good + 4'd1;
                end

                if (w_expired) begin
                    r_alive <= 1'b0;
                end else if (r_good == c_recovery) begin
                    r_alive <= 1'b1;
                end
            end
        end

        assign w_alive[gi] = r_alive;
    end

    logic [1:0] r_state;
    logic       r_select;
    logic       r_request;
    logic       r_no_clock;
    logic [7:0] r_count;
    logic       w_target;
    logic       w_target_valid;

    always_comb begin
        w_target_valid = 1'b1;
        w_target       = c_preferred;
        if (!c_revertive && w_alive[r_select]) begin
            w_target = r_select;
        end else if (w_alive[c_preferred]) begin
            w_target = c_preferred;
        end else if (w_alive[~c_preferred]) begin
            w_target = ~c_preferred;
        end else begin
            w_target_valid = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= c_st_none;
            r_select   <= c_preferred;
            r_request  <= 1'b0;
            r_no_clock <= 1'b1;
            r_count    <= 8'd0;
        end else begin
            r_no_clock <= ~(|w_alive);
            case (r_state)
                c_st_none, c_st_run: begin
                    if (!w_target_valid) begin
                        r_state <= c_st_none;
                    end else if (w_target == r_select) begin
                        r_state <= c_st_run;
                    end else begin
                        r_select  <= w_target;
                        r_request <= 1'b1;
                        r_state   <= c_st_switching;
                    end
                end
                c_st_switching: begin
                    // Liveness is deliberately ignored until the handshake ends
                    if (switch_acknowledge) begin
                        r_request <= 1'b0;
                        if (r_count != 8'hFF) begin
                            r_count <= r_count + 8'd1;
                        end
                        r_state <= c_st_run;
                    end
                end
                default: begin
                    r_state <= c_st_none;
                end
            endcase
        end
    end

    assign select         = r_select;
    assign switch_request = r_request;
    assign first_alive    = w_alive[0];
    assign second_alive   = w_alive[1];
    assign no_clock       = r_no_clock;
    assign switch_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_clock_failover_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clock_failover_controller
//  Description : Randomized bench for a revertive and a non-revertive
//                controller against a timestamp-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_failover_controller;

    localparam int c_timeout  = 16;
    localparam int c_recovery = 4;
    localparam int c_st_none  = 0;
    localparam int c_st_run   = 1;
    localparam int c_st_sw    = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       first_hb = 1'b0;
    logic       second_hb = 1'b0;
    logic [1:0] ack = 2'b00;
    logic [1:0] sel, req, fa, sa, nc;
    logic [7:0] cnt [2];

    always #5 clock = ~clock;

    clock_failover_controller #(
        .TIMEOUT(c_timeout), .RECOVERY(c_recovery), .PREFERRED(0), .REVERTIVE(1)
    ) u_rev (
        .clock(clock), .reset(reset),
        .first_heartbeat(first_hb), .second_heartbeat(second_hb),
        .switch_acknowledge(ack[0]),
        .select(sel[0]), .switch_request(req[0]),
        .first_alive(fa[0]), .second_alive(sa[0]),
        .no_clock(nc[0]), .switch_count(cnt[0])
    );

    clock_failover_controller #(
        .TIMEOUT(c_timeout), .RECOVERY(c_recovery), .PREFERRED(0), .REVERTIVE(0)
    ) u_nonrev (
        .clock(clock), .reset(reset),
        .first_heartbeat(first_hb), .second_heartbeat(second_hb),
        .switch_acknowledge(ack[1]),
        .select(sel[1]), .switch_request(req[1]),
        .first_alive(fa[1]), .second_alive(sa[1]),
        .no_clock(nc[1]), .switch_count(cnt[1])
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: source health from toggle timestamps, switching per dut
    int m_edge = 0;
    int m_last_event [2];
    int m_streak [2];
    bit m_alive [2];
    bit m_prev [2];
    int ms_state [2];
    bit ms_sel [2];
    bit ms_req [2];
    bit ms_nc [2];
    int ms_cnt [2];

    function automatic int pick_target(input bit revert, input bit cur, input bit a0, input bit a1);
        bit a [2];
        a[0] = a0;
        a[1] = a1;
        if (!revert && a[cur]) return int'(cur);
        if (a[0]) return 0;
        if (a[1]) return 1;
        return -1;
    endfunction

    task automatic model_edge();
        bit hb [2];
        bit old_alive [2];
        int target;
        int idle;
        bit dead;
        bit tog;
        hb[0] = first_hb;
        hb[1] = second_hb;
        old_alive[0] = m_alive[0];
        old_alive[1] = m_alive[1];
        m_edge++;
        if (reset) begin
            for (int s = 0; s < 2; s++) begin
                m_prev[s] = hb[s];
                m_last_event[s] = m_edge;
                m_streak[s] = 0;
                m_alive[s] = 1'b0;
            end
            for (int d = 0; d < 2; d++) begin
                ms_state[d] = c_st_none;
                ms_sel[d] = 1'b0;
                ms_req[d] = 1'b0;
                ms_nc[d] = 1'b1;
                ms_cnt[d] = 0;
            end
            return;
        end
        for (int d = 0; d < 2; d++) begin
            target = pick_target(d == 0, ms_sel[d], old_alive[0], old_alive[1]);
            ms_nc[d] = !(old_alive[0] || old_alive[1]);
            if (ms_state[d] == c_st_sw) begin
                if (ack[d]) begin
                    ms_req[d] = 1'b0;
                    ms_cnt[d] = (ms_cnt[d] < 255) ? ms_cnt[d] + 1 : 255;
                    ms_state[d] = c_st_run;
                end
            end else if (target < 0) begin
                ms_state[d] = c_st_none;
            end else if (target == int'(ms_sel[d])) begin
                ms_state[d] = c_st_run;
            end else begin
                ms_sel[d] = target[0];
                ms_req[d] = 1'b1;
                ms_state[d] = c_st_sw;
            end
        end
        for (int s = 0; s < 2; s++) begin
            idle = (m_edge - 1) - m_last_event[s];
            dead = (idle >= c_timeout);
            tog = (hb[s] != m_prev[s]);
            if (dead) m_alive[s] = 1'b0;
            else if (m_streak[s] >= c_recovery) m_alive[s] = 1'b1;
            if (tog) m_streak[s] = dead ? 1 : ((m_streak[s] < c_recovery) ? m_streak[s] + 1 : c_recovery);
            else if (dead) m_streak[s] = 0;
            if (tog) m_last_event[s] = m_edge;
            m_prev[s] = hb[s];
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("select[%0d]", d), 32'(sel[d]), 32'(ms_sel[d]));
            check($sformatf("switch_request[%0d]", d), 32'(req[d]), 32'(ms_req[d]));
            check($sformatf("first_alive[%0d]", d), 32'(fa[d]), 32'(m_alive[0]));
            check($sformatf("second_alive[%0d]", d), 32'(sa[d]), 32'(m_alive[1]));
            check($sformatf("no_clock[%0d]", d), 32'(nc[d]), 32'(ms_nc[d]));
            check($sformatf("switch_count[%0d]", d), 32'(cnt[d]), 32'(ms_cnt[d]));
        end
    endtask

    // Acknowledge responder: random latency while a request is open, sparse stray pulses otherwise
    bit hold_ack = 1'b0;
    int ack_wait [2] = '{0, 0};
    int ack_delay [2] = '{5, 3};

    task automatic drive_ack();
        for (int d = 0; d < 2; d++) begin
            if (hold_ack) begin
                ack[d] = 1'b0;
            end else if (req[d]) begin
                ack_wait[d]++;
                ack[d] = (ack_wait[d] >= ack_delay[d]);
                if (ack[d]) begin
                    ack_wait[d] = 0;
                    ack_delay[d] = int'($urandom_range(1, 6));
                end
            end else begin
                ack_wait[d] = 0;
                ack[d] = ($urandom_range(0, 7) == 0);
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        model_edge();
        compare_all();
        drive_ack();
    endtask

    task automatic run_phase(input int p0, input int p1, input int cycles);
        for (int c = 1; c <= cycles; c++) begin
            if (p0 > 0 && (c % p0) == 0) first_hb = ~first_hb;
            if (p1 > 0 && (c % p1) == 0) second_hb = ~second_hb;
            step();
        end
    endtask

    initial begin
        bit seen;
        int p0, p1;
        first_hb  = 1'($urandom);
        second_hb = 1'($urandom);
        reset = 1'b1;
        repeat (3) step();
        check("reset_select", 32'(sel[0]), 0);
        check("reset_request", 32'(req[0]), 0);
        check("reset_alive", 32'({fa[0], sa[0]}), 0);
        check("reset_no_clock", 32'(nc[0]), 1);
        check("reset_count", 32'(cnt[0]), 0);
        reset = 1'b0;

        run_phase(3, 0, 30);
        check("startup_alive", 32'(fa[0]), 1);
        check("startup_select", 32'(sel[0]), 0);
        check("startup_count", 32'(cnt[0]), 0);

        run_phase(0, 2, 45);
        check("failover_select", 32'({sel[1], sel[0]}), 32'b11);
        check("failover_first_dead", 32'(fa[0]), 0);
        check("failover_count", 32'(cnt[0]), 1);

        run_phase(3, 2, 30);
        check("revert_select", 32'(sel[0]), 0);
        check("revert_count", 32'(cnt[0]), 2);
        check("nonrevert_select", 32'(sel[1]), 1);
        check("nonrevert_count", 32'(cnt[1]), 1);

        run_phase(0, 0, 30);
        check("loss_no_clock", 32'({nc[1], nc[0]}), 32'b11);
        check("loss_select", 32'(sel[0]), 0);
        check("loss_request", 32'(req[0]), 0);
        run_phase(3, 0, 30);
        check("restart_count", 32'(cnt[0]), 2);
        check("restart_select", 32'(sel[0]), 0);

        // Open a handshake on the revertive controller, then reset under it
        hold_ack = 1'b1;
        seen = 1'b0;
        for (int c = 1; c <= 80 && !seen; c++) begin
            if ((c % 2) == 0) second_hb = ~second_hb;
            step();
            seen = req[0];
        end
        check("handshake_opened", 32'(seen), 1);
        reset = 1'b1;
        step();
        check("midreset_request", 32'(req[0]), 0);
        check("midreset_select", 32'(sel[0]), 0);
        check("midreset_count", 32'(cnt[0]), 0);
        check("midreset_no_clock", 32'(nc[0]), 1);
        reset = 1'b0;
        ack = 2'b11;
        step();
        ack = 2'b00;
        step();
        check("late_ack_count", 32'(cnt[0]), 0);
        check("late_ack_request", 32'(req[0]), 0);
        hold_ack = 1'b0;

        for (int ph = 0; ph < 60; ph++) begin
            p0 = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, c_timeout + 2));
            p1 = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, c_timeout + 2));
            if ($urandom_range(0, 14) == 0) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
            end
            run_phase(p0, p1, int'($urandom_range(10, 60)));
        end

        // Alternate failover and revert until the counter must have saturated
        for (int r = 0; r < 140; r++) begin
            run_phase(0, 2, 30);
            run_phase(3, 2, 30);
        end
        check("saturated_count", 32'(cnt[0]), 255);
        run_phase(0, 2, 30);
        run_phase(3, 2, 30);
        check("saturated_hold", 32'(cnt[0]), 255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clock_failover_controller.md
CLOCK_FAILOVER_CONTROLLER -- requirements
Module: clock_failover_controller

Interface
REQ-001 Parameter TIMEOUT, default 16, meaning: consecutive cycles without a heartbeat toggle after which a source is declared dead (range 2..255).
REQ-002 Parameter RECOVERY, default 4, meaning: consecutive heartbeat toggles, each within TIMEOUT cycles of the previous, required to declare a source alive (range 1..15).
REQ-003 Parameter PREFERRED, default 0, meaning: preferred source (0 first, 1 second).
REQ-004 Parameter REVERTIVE, default 1, meaning: 1 returns to PREFERRED once it is alive again; 0 stays on the current source.
REQ-005 clock  input  1  controller clock; the only clock; all logic is on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 first_heartbeat  input  1  toggle signal from the first clock domain, already synchronized to clock.
REQ-008 second_heartbeat  input  1  toggle signal from the second clock domain, already synchronized to clock.
REQ-009 switch_acknowledge  input  1  switchover selector reports that the requested switch is complete.
REQ-010 select  output  1  selected source (0 first, 1 second).
REQ-011 switch_request  output  1  switch in progress toward select.
REQ-012 first_alive / second_alive  output  1 each  health status per source.
REQ-013 no_clock  output  1  neither source is alive.
REQ-014 switch_count  output  8  completed switches, saturating at 255.

Function
REQ-015 Per-source monitor: a toggle is detected when the heartbeat differs from its value registered on the previous cycle.
REQ-016 Silence counter: cleared on a toggle; otherwise increments, saturating at TIMEOUT.
REQ-017 Good counter: increments on a toggle, saturating at RECOVERY; cleared when the silence counter reaches TIMEOUT.
REQ-018 A source's alive output rises on the cycle after the good counter reaches RECOVERY.
REQ-019 A source's alive output falls on the cycle after the silence counter reaches TIMEOUT.
REQ-020 The target source is chosen as follows:
- PREFERRED if alive;
- else the other source if alive;
- else none.
- When REVERTIVE=0 and the current source is alive, the target is the current source.
REQ-021 FSM states are NONE, RUN and SWITCHING.
REQ-022 NONE -> RUN when the target equals select, with no handshake.
REQ-023 NONE -> SWITCHING when the target differs from select.
REQ-024 RUN -> SWITCHING when a target exists and it differs from select.
REQ-025 RUN -> NONE when no source is alive; select is held.
REQ-026 On entry to SWITCHING, select takes the target value and switch_request is set, both in the same cycle.
REQ-027 switch_request and select are held stable until switch_acknowledge is sampled high.
REQ-028 On the acknowledge cycle: switch_request clears on the next edge, switch_count increments, and the state goes to RUN.
REQ-029 Liveness changes during SWITCHING do not abort the handshake; they are re-evaluated in RUN on the following cycle.
REQ-030 switch_acknowledge is ignored outside SWITCHING.
REQ-031 no_clock = NOT first_alive AND NOT second_alive, registered.
REQ-032 If both sources are alive and revert is pending, at most one switch starts per RUN cycle; back-to-back switches are separated by at least one RUN cycle.

Reset
REQ-033 While reset is high, the controller is held in reset at every edge.
REQ-034 Reset values:
- select = PREFERRED;
- switch_request = 0;
- first_alive = second_alive = 0;
- no_clock = 1;
- switch_count = 0;
- all counters = 0;
- state = NONE.
REQ-035 A reset asserted mid-handshake drops switch_request on the next edge without waiting for switch_acknowledge.
REQ-036 Previous-heartbeat registers load the current input during reset, so that no toggle is detected on the first cycle after reset.

Verification
REQ-037 Start-up: reset, then first_heartbeat toggles every 3 cycles, second silent -> first_alive=1 after the 4th toggle; state RUN; select=0; switch_request never asserted; switch_count=0.
REQ-038 Failover: from that RUN state, stop first and start second toggling every 2 cycles -> second_alive=1 after 4 toggles; first_alive=0 after 16 silent cycles; select=1 and switch_request=1 in the same cycle; ack after 5 cycles -> request low next cycle; switch_count=1.
REQ-039 Revert: restart first with REVERTIVE=1 -> after 4 toggles a switch to select=0 occurs and switch_count=2. With REVERTIVE=0 -> select stays 1 and switch_count stays 1.
REQ-040 Total loss: both sources silent for 16 cycles -> no_clock=1, select unchanged, no request. Restarting the same source gives RUN without a handshake.
REQ-041 Reset mid-handshake: assert reset while switch_request=1 -> next edge gives switch_request=0, select=PREFERRED, switch_count=0, no_clock=1. A late switch_acknowledge after reset has no effect.
REQ-042 Saturation: force 260 completed switches -> switch_count=255 and stays 255.
